// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default widths and the
// flush handshake state encoding. No ports.
package dmem_pkg;

  localparam int DMEM_DATA_W   = 32;
  localparam int DMEM_AW       = 8;
  localparam int DMEM_WB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } flush_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// In-order write buffer: circular storage of {index, data} entries with
// push/pop pointers, an occupancy count and a combinational lookup that
// returns the youngest entry matching a RAM index.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   push, push_idx/data     enqueue one entry (caller guarantees not full)
//   pop                     dequeue the oldest entry (caller guarantees not empty)
//   head_idx, head_data     oldest entry, valid when not empty
//   count, full, empty      occupancy
//   lookup_idx              index to search for
//   hit, hit_data           youngest matching entry, if any
module wbuf_fifo #(
  parameter int DATA_W   = 32,
  parameter int AW       = 8,
  parameter int WB_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [AW-1:0]             push_idx,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [AW-1:0]             head_idx,
  output logic [DATA_W-1:0]         head_data,
  output logic [$clog2(WB_DEPTH):0] count,
  output logic                      full,
  output logic                      empty,
  input  logic [AW-1:0]             lookup_idx,
  output logic                      hit,
  output logic [DATA_W-1:0]         hit_data
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]     idx_q  [WB_DEPTH];
  logic [DATA_W-1:0] data_q [WB_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     slot;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; occupancy is tracked by count, so stale
  // slots are never observed and the array maps onto plain registers/RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      idx_q[wr_ptr]  <= push_idx;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_idx  = idx_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign full      = (count == CW'(WB_DEPTH));
  assign empty     = (count == '0);

  // Walk valid entries oldest to youngest so a later match overrides an
  // earlier one, leaving the youngest match on the outputs.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (idx_q[slot] == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[slot];
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf_responder.sv
// MEM-stage data-port responder. Writes are buffered and drained into a
// single-port word RAM in cycles without a read; reads see the youngest
// buffered write first, then the RAM. A flush handshake empties the buffer.
//
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   ren, wen       read / write request
//   addr           word address; only addr[AW-1:0] selects a RAM word
//   wdata          write data
//   rdata          combinational read data, 0 when ren is low
//   stall          CPU must hold its request
//   flush          level request to drain the buffer
//   flush_done     one-cycle pulse when the drain completes
//   wb_count       occupied buffer entries
module dmem_wbuf_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int AW       = DMEM_AW,
  parameter int DEPTH    = 1 << AW,
  parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ren,
  input  logic                      wen,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      stall,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  logic [DATA_W-1:0] ram [DEPTH];
  flush_state_e      state;

  logic [AW-1:0]     idx;
  logic              unused_addr_hi;
  logic              in_flush;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [AW-1:0]     head_idx;
  logic [DATA_W-1:0] head_data;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  // Upper address bits alias onto the same RAM word.
  assign idx            = addr[AW-1:0];
  assign unused_addr_hi = ^addr[31:AW];

  assign in_flush = (state == FLUSH);
  assign stall    = (wen & full) | (in_flush & (ren | wen));
  // A full buffer refuses the write even if a drain frees a slot this cycle.
  assign push     = wen & ~stall;
  // The RAM port belongs to reads except while flushing.
  assign pop      = ~empty & (~ren | in_flush);

  wbuf_fifo #(
    .DATA_W   (DATA_W),
    .AW       (AW),
    .WB_DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_idx   (idx),
    .push_data  (wdata),
    .pop        (pop),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .count      (wb_count),
    .full       (full),
    .empty      (empty),
    .lookup_idx (idx),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  always_ff @(posedge clock) begin
    if (pop) ram[head_idx] <= head_data;
  end

  // Reads observe pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rdata = '0;
    if (ren) rdata = hit ? hit_data : ram[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        IDLE:    if (flush) state <= FLUSH;
        FLUSH: begin
          // Occupancy is judged before this edge's drain, so an empty
          // buffer at entry still costs one FLUSH cycle.
          if (empty) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE:    if (!flush) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Self-checking bench for dmem_wbuf_responder. A flat architectural memory
// model supplies expected read data, which is queued when a request is
// driven and compared when the DUT answers.
module tb_dmem_wbuf_responder;

  logic        clock;
  logic        reset;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic        flush_done;
  logic [2:0]  wb_count;

  int n_checks;
  int n_fail;

  logic [31:0] model_mem [logic [7:0]];
  logic [31:0] sb_q [$];

  dmem_wbuf_responder dut (
    .clock      (clock),
    .reset      (reset),
    .ren        (ren),
    .wen        (wen),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .flush      (flush),
    .flush_done (flush_done),
    .wb_count   (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    return model_mem.exists(i) ? model_mem[i] : 32'h0;
  endfunction

  // One CPU cycle: drive at the falling edge, compare mid-low-phase, and the
  // following rising edge commits it.
  task automatic drive(input string tag, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic f,
                       input logic exp_stall, input int exp_count, input logic exp_fd);
    logic [31:0] exp_rd;
    @(negedge clock);
    ren = r; wen = w; addr = a; wdata = d; flush = f;
    sb_q.push_back(r ? model_read(a) : 32'h0);
    #2;
    exp_rd = sb_q.pop_front();
    check($sformatf("%s.rdata", tag), rdata, exp_rd);
    check($sformatf("%s.stall", tag), 32'(stall), 32'(exp_stall));
    check($sformatf("%s.wb_count", tag), 32'(wb_count), 32'(exp_count));
    check($sformatf("%s.flush_done", tag), 32'(flush_done), 32'(exp_fd));
    if (w && !exp_stall) model_mem[a[7:0]] = d;
  endtask

  task automatic idle(input string tag, input int exp_count);
    drive(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, exp_count, 1'b0);
  endtask

  initial begin
    logic [31:0] pre_addr [9];
    logic [31:0] old20;
    logic [31:0] old21;

    pre_addr = '{5, 9, 20, 21, 0, 1, 2, 4, 7};
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; flush = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    #2;
    check("reset.wb_count", 32'(wb_count), 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.flush_done", 32'(flush_done), 32'd0);
    check("reset.rdata", rdata, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Preload RAM through the port; each write enqueues while the previous drains.
    foreach (pre_addr[i])
      drive("preload", 1'b0, 1'b1, pre_addr[i], 32'hAAAA0000 | pre_addr[i], 1'b0, 1'b0,
            (i == 0) ? 0 : 1, 1'b0);
    idle("preload_drain", 1);
    idle("preload_empty", 0);

    // Test 1: plain RAM read, plus upper address bits aliasing.
    drive("t1_read5", 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    drive("t1_alias", 1'b1, 1'b0, 32'h105, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Test 2: back-to-back writes enqueue and drain in the same cycle.
    drive("t2_w0", 1'b0, 1'b1, 32'd3, 32'h11, 1'b0, 1'b0, 0, 1'b0);
    drive("t2_w1", 1'b0, 1'b1, 32'd3, 32'h11, 1'b0, 1'b0, 1, 1'b0);
    idle("t2_drain", 1);
    drive("t2_read3", 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Test 3: reads block draining, buffer fills, fifth write stalls.
    for (int i = 0; i < 4; i++)
      drive($sformatf("t3_w%0d", i), 1'b1, 1'b1, i, 32'h30000000 + i, 1'b0, 1'b0, i, 1'b0);
    drive("t3_full_rd", 1'b1, 1'b1, 32'd4, 32'h30000004, 1'b0, 1'b1, 4, 1'b0);
    drive("t3_full_nrd", 1'b0, 1'b1, 32'd4, 32'h30000004, 1'b0, 1'b1, 4, 1'b0);
    drive("t3_accept", 1'b0, 1'b1, 32'd4, 32'h30000004, 1'b0, 1'b0, 3, 1'b0);
    idle("t3_d3", 3);
    idle("t3_d2", 2);
    idle("t3_d1", 1);
    for (int i = 0; i < 5; i++)
      drive($sformatf("t3_rd%0d", i), 1'b1, 1'b0, i, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Test 4: duplicate addresses, youngest wins in buffer and in RAM.
    drive("t4_w22", 1'b1, 1'b1, 32'd7, 32'h22, 1'b0, 1'b0, 0, 1'b0);
    drive("t4_w33", 1'b1, 1'b1, 32'd7, 32'h33, 1'b0, 1'b0, 1, 1'b0);
    drive("t4_rdbuf", 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 2, 1'b0);
    idle("t4_d2", 2);
    idle("t4_d1", 1);
    drive("t4_rdram", 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Test 5: flush with three entries pending.
    for (int i = 0; i < 3; i++)
      drive($sformatf("t5_w%0d", i), 1'b1, 1'b1, i, 32'h50000000 + i, 1'b0, 1'b0, i, 1'b0);
    drive("t5_req", 1'b1, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 3, 1'b0);
    drive("t5_fl1", 1'b1, 1'b1, 32'd9, 32'hBAD, 1'b1, 1'b1, 3, 1'b0);
    drive("t5_fl2", 1'b0, 1'b1, 32'd9, 32'hBAD, 1'b1, 1'b1, 2, 1'b0);
    drive("t5_fl3", 1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    drive("t5_fl4", 1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    drive("t5_pulse", 1'b1, 1'b0, 32'd2, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    drive("t5_done", 1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    drive("t5_release", 1'b0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    drive("t5_rd9", 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Test 6: reset in the middle of a flush discards pending writes.
    old20 = model_read(32'd20);
    old21 = model_read(32'd21);
    drive("t6_w20", 1'b1, 1'b1, 32'd20, 32'hDEAD0020, 1'b0, 1'b0, 0, 1'b0);
    drive("t6_w21", 1'b1, 1'b1, 32'd21, 32'hDEAD0021, 1'b0, 1'b0, 1, 1'b0);
    drive("t6_req", 1'b1, 1'b0, 32'd20, 32'h0, 1'b1, 1'b0, 2, 1'b0);
    @(negedge clock);
    reset = 1'b1; ren = 1'b0; wen = 1'b0; flush = 1'b0;
    #2;
    check("t6_rst.wb_count", 32'(wb_count), 32'd0);
    check("t6_rst.flush_done", 32'(flush_done), 32'd0);
    check("t6_rst.stall", 32'(stall), 32'd0);
    model_mem[8'd20] = old20;
    model_mem[8'd21] = old21;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) idle($sformatf("t6_quiet%0d", i), 0);
    drive("t6_rd20", 1'b1, 1'b0, 32'd20, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    drive("t6_rd21", 1'b1, 1'b0, 32'd21, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
